// File: rtl/pixel_pkg.sv
// Shared types and helpers for the pixel frame sequencer and related pattern blocks.
package pixel_pkg;

  localparam int CHAN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PRESENT,
    ST_EOF
  } seq_state_t;

  // Upper byte of c*(b+1): b=255 is unity gain, b=0 gives 0.
  function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                   input logic [CHAN_W-1:0] b);
    logic [2*CHAN_W-1:0] prod;
    prod = {{CHAN_W{1'b0}}, c} * ({{CHAN_W{1'b0}}, b} + (2*CHAN_W)'(1));
    return prod[2*CHAN_W-1:CHAN_W];
  endfunction

endpackage

// File: rtl/panel_index_mapper.sv
// Combinational row/col/offset to pattern index mapping with optional serpentine
// wiring and wrap-around scroll offset.
module panel_index_mapper
  import pixel_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int IDX_W      = 10,
  parameter int SERPENTINE = 1,
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [IDX_W-1:0] offset,
  output logic [IDX_W-1:0] index
);

  localparam int PX_COUNT = COLS * ROWS;

  logic [COL_W-1:0] col_phys;
  logic [IDX_W-1:0] phys;
  logic [IDX_W:0]   sum;

  always_comb begin
    col_phys = col;
    if ((SERPENTINE != 0) && row[0])
      col_phys = COL_W'(COLS - 1) - col;
    phys = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col_phys);
    // Both terms are below PX_COUNT, so one conditional subtract wraps the sum.
    sum = {1'b0, phys} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(PX_COUNT))
      sum = sum - (IDX_W+1)'(PX_COUNT);
    index = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Walks the panel pixel by pixel, fetches colour from the pattern source, scales it
// by global brightness and streams pixels plus an end-of-frame beat to the driver.
module pixel_frame_sequencer
  import pixel_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int IDX_W      = 10,
  parameter int SERPENTINE = 1,
  parameter int SCROLL_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              scroll_en,
  input  logic              scroll_dir,
  input  logic [CHAN_W-1:0] brightness,
  output logic              src_valid,
  output logic [IDX_W-1:0]  src_index,
  input  logic              src_ready,
  input  logic [CHAN_W-1:0] src_red,
  input  logic [CHAN_W-1:0] src_green,
  input  logic [CHAN_W-1:0] src_blue,
  output logic              drv_valid,
  input  logic              drv_ready,
  output logic [CHAN_W-1:0] drv_red,
  output logic [CHAN_W-1:0] drv_green,
  output logic [CHAN_W-1:0] drv_blue,
  output logic              drv_frame_end,
  output logic [15:0]       frame_count
);

  localparam int PX_COUNT = COLS * ROWS;
  localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PX_COUNT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  seq_state_t        state, state_nxt;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [IDX_W-1:0]  offset;
  logic [IDX_W-1:0]  index_map;
  logic [DIV_W-1:0]  div_cnt;
  logic [CHAN_W-1:0] red_p1, green_p1, blue_p1;
  logic              cap, px_hs, eof_hs, last_px;

  function automatic logic [IDX_W-1:0] step_offset(input logic [IDX_W-1:0] off,
                                                   input logic up);
    if (up)
      return (off == IDX_LAST) ? '0 : off + 1'b1;
    return (off == '0) ? IDX_LAST : off - 1'b1;
  endfunction

  panel_index_mapper #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .IDX_W     (IDX_W),
    .SERPENTINE(SERPENTINE),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W)
  ) u_mapper (
    .row   (row),
    .col   (col),
    .offset(offset),
    .index (index_map)
  );

  assign last_px = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    src_valid     = 1'b0;
    src_index     = '0;
    drv_valid     = 1'b0;
    drv_frame_end = 1'b0;
    drv_red       = '0;
    drv_green     = '0;
    drv_blue      = '0;
    cap           = 1'b0;
    px_hs         = 1'b0;
    eof_hs        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable)
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        src_valid = 1'b1;
        src_index = index_map;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (src_ready) begin
          cap       = 1'b1;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        drv_valid = 1'b1;
        drv_red   = red_p1;
        drv_green = green_p1;
        drv_blue  = blue_p1;
        if (drv_ready) begin
          px_hs     = 1'b1;
          state_nxt = last_px ? ST_EOF : ST_REQ;
        end
      end
      ST_EOF: begin
        drv_valid     = 1'b1;
        drv_frame_end = 1'b1;
        if (drv_ready) begin
          eof_hs    = 1'b1;
          state_nxt = enable ? ST_REQ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row         <= '0;
      col         <= '0;
      offset      <= '0;
      div_cnt     <= '0;
      frame_count <= '0;
    end else begin
      if ((state == ST_IDLE) && enable) begin
        row <= '0;
        col <= '0;
      end
      if (px_hs) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= last_px ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (eof_hs) begin
        frame_count <= frame_count + 16'd1;
        if (scroll_en) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            offset  <= step_offset(offset, scroll_dir);
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: scaled source colour, held for the driver until accepted.
  always_ff @(posedge clk) begin
    if (cap) begin
      red_p1   <= scale_chan(src_red, brightness);
      green_p1 <= scale_chan(src_green, brightness);
      blue_p1  <= scale_chan(src_blue, brightness);
    end
  end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Scoreboard bench for pixel_frame_sequencer on a 4x2 serpentine panel.
module tb_pixel_frame_sequencer;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int PX      = COLS * ROWS;
  localparam int IDX_W   = 4;
  localparam int STALL_N = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             scroll_en;
  logic             scroll_dir;
  logic [7:0]       brightness;
  logic             src_valid;
  logic [IDX_W-1:0] src_index;
  logic             src_ready;
  logic [7:0]       src_red, src_green, src_blue;
  logic             drv_valid;
  logic             drv_ready;
  logic [7:0]       drv_red, drv_green, drv_blue;
  logic             drv_frame_end;
  logic [15:0]      frame_count;

  always #5 clk = ~clk;

  pixel_frame_sequencer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .IDX_W     (IDX_W),
    .SERPENTINE(1),
    .SCROLL_DIV(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .scroll_en    (scroll_en),
    .scroll_dir   (scroll_dir),
    .brightness   (brightness),
    .src_valid    (src_valid),
    .src_index    (src_index),
    .src_ready    (src_ready),
    .src_red      (src_red),
    .src_green    (src_green),
    .src_blue     (src_blue),
    .drv_valid    (drv_valid),
    .drv_ready    (drv_ready),
    .drv_red      (drv_red),
    .drv_green    (drv_green),
    .drv_blue     (drv_blue),
    .drv_frame_end(drv_frame_end),
    .frame_count  (frame_count)
  );

  int total = 0;
  int bad   = 0;

  int          off_m, fc_m, px_req, px_drv, frames_done;
  bit          fc_pending, saw_req;
  int          stall_at, stall_left, drop_at, src_lat, src_wait;
  logic [23:0] hold_val;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_index(input int k, input int off);
    int r, c;
    r = k / COLS;
    c = k % COLS;
    if (r % 2 == 1)
      c = COLS - 1 - c;
    return (r * COLS + c + off) % PX;
  endfunction

  function automatic int scale_m(input int c, input int b);
    return (c * (b + 1)) / 256;
  endfunction

  task automatic step();
    logic [7:0] r, g, b;
    int idx;
    @(negedge clk);
    if (fc_pending) begin
      chk("frame_count", frame_count, fc_m);
      fc_pending = 0;
    end
    saw_req = 0;
    if (src_valid) begin
      saw_req = 1;
      chk("src_index", src_index, exp_index(px_req, off_m));
      idx = int'(src_index);
      r = (px_req == 0) ? 8'd200 : 8'(idx * 29 + 7);
      g = 8'(idx * 17 + 3);
      b = 8'(255 - idx * 11);
      px_req++;
      src_red   = r;
      src_green = g;
      src_blue  = b;
      src_wait  = src_lat;
      src_ready = (src_lat == 0);
      exp_q.push_back({8'(scale_m(r, brightness)), 8'(scale_m(g, brightness)),
                       8'(scale_m(b, brightness))});
    end else if (src_wait > 0) begin
      src_wait--;
      if (src_wait == 0)
        src_ready = 1'b1;
    end

    drv_ready = 1'b1;
    if (stall_left > 0 &&
        (stall_left < STALL_N || (drv_valid && !drv_frame_end && px_drv == stall_at))) begin
      if (stall_left == STALL_N) begin
        hold_val = {drv_red, drv_green, drv_blue};
      end else begin
        chk("stall_valid", drv_valid, 1);
        chk("stall_hold", {drv_red, drv_green, drv_blue}, hold_val);
        chk("stall_nosrc", src_valid, 0);
      end
      drv_ready = 1'b0;
      stall_left--;
    end

    if (drv_valid && drv_ready) begin
      if (drv_frame_end) begin
        chk("eof_colour", {drv_red, drv_green, drv_blue}, 0);
        chk("eof_px", px_drv, PX);
        fc_m = (fc_m + 1) & 16'hffff;
        fc_pending = 1;
        if (scroll_en)
          off_m = scroll_dir ? (off_m + 1) % PX : (off_m + PX - 1) % PX;
        px_req = 0;
        px_drv = 0;
        frames_done++;
      end else begin
        if (exp_q.size() == 0)
          chk("drv_unexpected", exp_q.size(), 1);
        else
          chk("drv_colour", {drv_red, drv_green, drv_blue}, exp_q.pop_front());
        px_drv++;
        if (px_drv == drop_at)
          enable = 1'b0;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int target;
    int budget;
    target = frames_done + n;
    budget = 0;
    while (frames_done < target && budget < 3000) begin
      step();
      budget++;
    end
    if (frames_done < target)
      chk("frame_timeout", frames_done, target);
  endtask

  task automatic set_scroll(input logic en, input logic dir);
    step();
    scroll_en  = en;
    scroll_dir = dir;
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0;
    brightness = 8'd255; src_ready = 1'b0; drv_ready = 1'b0;
    src_red = '0; src_green = '0; src_blue = '0;
    off_m = 0; fc_m = 0; px_req = 0; px_drv = 0; frames_done = 0;
    fc_pending = 0; saw_req = 0; stall_at = -1; stall_left = 0; drop_at = -1;
    src_lat = 0; src_wait = 0; hold_val = '0;

    repeat (3) @(negedge clk);
    chk("rst_src_valid", src_valid, 0);
    chk("rst_src_index", src_index, 0);
    chk("rst_drv_valid", drv_valid, 0);
    chk("rst_frame_end", drv_frame_end, 0);
    chk("rst_drv_rgb", {drv_red, drv_green, drv_blue}, 0);
    chk("rst_frame_count", frame_count, 0);
    reset = 1'b0;

    // Frame 1 at offset 0; scrolling down from its end onward.
    scroll_en = 1'b1; scroll_dir = 1'b0; enable = 1'b1;
    run_frames(1);
    run_frames(1);
    brightness = 8'd127; src_lat = 2;
    run_frames(1);
    brightness = 8'd0; src_lat = 0;
    set_scroll(1'b1, 1'b1);
    run_frames(1);
    brightness = 8'd180;
    run_frames(2);
    brightness = 8'd200; stall_at = 3; stall_left = STALL_N;
    run_frames(1);
    brightness = 8'd255; stall_at = -1;
    set_scroll(1'b0, 1'b0);
    drop_at = 2;
    run_frames(1);
    drop_at = -1;
    chk("enable_dropped", enable, 0);
    repeat (12) begin
      step();
      chk("idle_src_valid", src_valid, 0);
      chk("idle_drv_valid", drv_valid, 0);
    end

    // Reset while waiting on the source abandons the frame and clears the offset.
    enable = 1'b1; src_lat = 3;
    n = 0;
    saw_req = 0;
    while (!saw_req && n < 50) begin
      step();
      n++;
    end
    chk("req_seen", saw_req, 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("wrst_src_valid", src_valid, 0);
    chk("wrst_drv_valid", drv_valid, 0);
    chk("wrst_frame_end", drv_frame_end, 0);
    chk("wrst_drv_rgb", {drv_red, drv_green, drv_blue}, 0);
    chk("wrst_frame_count", frame_count, 0);
    reset = 1'b0; src_lat = 0; src_wait = 0; src_ready = 1'b1;
    off_m = 0; fc_m = 0; px_req = 0; px_drv = 0; fc_pending = 0;
    exp_q.delete();
    run_frames(1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
